// File: rtl/ddram_pkg.sv
// Shared types and constants for the DDRAM write buffer.
package ddram_pkg;

    localparam int unsigned DDR_AW = 29;
    localparam int unsigned DDR_DW = 64;
    localparam int unsigned DDR_BW = 8;

    localparam logic [DDR_BW-1:0] BE_FULL = 8'hFF;

    typedef struct packed {
        logic [DDR_AW-1:0] addr;
        logic [DDR_DW-1:0] data;
        logic [DDR_BW-1:0] be;
    } ddr_wr_t;

    // Overlay the bytes of new_d selected by be onto old_d.
    function automatic logic [DDR_DW-1:0] merge_bytes(input logic [DDR_DW-1:0] old_d,
                                                      input logic [DDR_DW-1:0] new_d,
                                                      input logic [DDR_BW-1:0] be);
        logic [DDR_DW-1:0] r;
        r = old_d;
        for (int b = 0; b < int'(DDR_BW); b++) begin
            if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ddram_wr_fifo_if.sv
// DDRAM write port bundle; master is the write buffer, slave is the DDR arbiter.
interface ddram_wr_fifo_if;
    import ddram_pkg::*;

    logic                DDRAM_CLK;
    logic                DDRAM_BUSY;
    logic [7:0]          DDRAM_BURSTCNT;
    logic [DDR_AW-1:0]   DDRAM_ADDR;
    logic [DDR_DW-1:0]   DDRAM_DIN;
    logic [DDR_BW-1:0]   DDRAM_BE;
    logic                DDRAM_WE;
    logic                DDRAM_RD;

    modport master (
        output DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
        input  DDRAM_BUSY
    );

    modport slave (
        input  DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
        output DDRAM_BUSY
    );

endinterface

// File: rtl/ddram_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens on the same edge.
module ddram_sync_fifo #(
    parameter int unsigned W          = 101,
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout_c,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    do_push_c;
    logic                    do_pop_c;
    logic [LW-1:0]           level_nxt_c;

    // Qualify push/pop and compute the next occupancy.
    always_comb begin
        do_pop_c    = pop & ~empty;
        do_push_c   = push & (~full | do_pop_c);
        level_nxt_c = level;
        if (do_push_c & ~do_pop_c)      level_nxt_c = level + LW'(1);
        else if (do_pop_c & ~do_push_c) level_nxt_c = level - LW'(1);
    end

    // Pointers wrap naturally at 2**DEPTH_LOG2; flags are registered from the next level.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level <= level_nxt_c;
            full  <= (level_nxt_c == LW'(DEPTH));
            empty <= (level_nxt_c == '0);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= din;
    end

    assign dout_c = mem[rd_ptr];

endmodule

// File: rtl/ddram_wr_fifo.sv
// Pixel write buffer: merges half-word writes, queues them and drains to DDRAM under BUSY.
module ddram_wr_fifo
    import ddram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter bit          MERGE      = 1'b1,
    parameter int unsigned IDLE_FLUSH = 4
) (
    input  logic                CLK_VIDEO,
    input  logic                reset,
    input  logic                in_we,
    input  logic [DDR_AW-1:0]   in_addr,
    input  logic [DDR_DW-1:0]   in_din,
    input  logic [DDR_BW-1:0]   in_be,
    input  logic                flush,
    ddram_wr_fifo_if.master     ddr,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow
);

    localparam int unsigned IW = 4;
    localparam int unsigned W  = $bits(ddr_wr_t);

    ddr_wr_t          stage_q;
    logic             stage_v_q;
    logic [IW-1:0]    idle_q;
    ddr_wr_t          out_q;
    logic             out_v_q;
    ddr_wr_t          fifo_head_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic             merge_c;
    logic             push_c;
    logic             pop_c;

    // Staging decisions and FIFO pop request.
    always_comb begin
        merge_c = in_we & stage_v_q & MERGE & (in_addr == stage_q.addr) & (stage_q.be != BE_FULL);
        push_c  = 1'b0;
        if (in_we) begin
            push_c = stage_v_q & ~merge_c;
        end else begin
            push_c = stage_v_q & ((stage_q.be == BE_FULL) | flush |
                                  (idle_q == IW'(IDLE_FLUSH - 1)));
        end
        pop_c = ~fifo_empty & (~out_v_q | ~ddr.DDRAM_BUSY);
    end

    ddram_sync_fifo #(
        .W          (W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk    (CLK_VIDEO),
        .reset  (reset),
        .push   (push_c),
        .din    (stage_q),
        .pop    (pop_c),
        .dout_c (fifo_head_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    // Staging register: merge, load (displacing the old entry) or retire on idle/flush/full word.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            stage_q   <= '0;
            stage_v_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            if (merge_c) begin
                stage_q.be   <= stage_q.be | in_be;
                stage_q.data <= merge_bytes(stage_q.data, in_din, in_be);
            end else if (in_we) begin
                stage_q   <= '{addr: in_addr, data: in_din, be: in_be};
                stage_v_q <= 1'b1;
            end else if (push_c) begin
                stage_v_q <= 1'b0;
            end
            if (in_we | push_c)  idle_q <= '0;
            else if (stage_v_q)  idle_q <= idle_q + IW'(1);
        end
    end

    // Output register: holds under BUSY, reloads from the FIFO head on each completed transfer.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            out_q   <= '0;
            out_v_q <= 1'b0;
        end else if (pop_c) begin
            out_q   <= fifo_head_c;
            out_v_q <= 1'b1;
        end else if (~ddr.DDRAM_BUSY) begin
            out_v_q <= 1'b0;
        end
    end

    // Sticky drop flag.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset)                              overflow <= 1'b0;
        else if (push_c & fifo_full & ~pop_c)   overflow <= 1'b1;
    end

    assign ddr.DDRAM_CLK      = CLK_VIDEO;
    assign ddr.DDRAM_BURSTCNT = 8'd1;
    assign ddr.DDRAM_RD       = 1'b0;
    assign ddr.DDRAM_ADDR     = out_q.addr;
    assign ddr.DDRAM_DIN      = out_q.data;
    assign ddr.DDRAM_BE       = out_q.be;
    assign ddr.DDRAM_WE       = out_v_q;

endmodule
